seven_seg_scan: RTL and testbench

Parametrised multiplexed seven-segment driver: time-division scans `NUM_DIGITS` display digits from a double-buffered value register, with hex decoding, decimal points, per-digit blanking and PWM brightness. It sits between the vote-count/BCD logic and the board display pins, and replaces the fixed 4-digit scanner for boards with wider displays or a different drive polarity.

---
 rtl/seven_seg_scan.sv | 224 ++++++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Multiplexed seven-segment driver. Scans NUM_DIGITS digits out of
//             a double-buffered value register. Provides hex decoding, decimal
//             points, per-digit blanking and PWM brightness.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_DIGITS  - number of scanned digits (2..8)
//    SCAN_DIV    - clock cycles per digit slot (>= 8)
//    ACTIVE_LOW  - 1: segments/digit enables active-low, 0: active-high
//  Ports
//    clk_100MHz  in   system clock
//    reset       in   asynchronous, active-high reset
//    digits_in   in   4-bit code per digit; [3:0] is digit 0 (rightmost)
//    dp_in       in   decimal point request per digit
//    blank_in    in   force digit dark
//    brightness  in   duty level 0..7 (sampled live)
//    update      in   capture digits_in/dp_in/blank_in into shadow
//    seg         out  segments, seg[0]=a .. seg[6]=g
//    dp          out  decimal point segment
//    digit       out  digit enables, bit i drives digit i
//    frame_done  out  one-cycle pulse after the last slot of a frame
//  Configuration macro
//    SEVEN_SEG_LZB_EN - when defined, leading-zero blanking is enabled
// ============================================================================
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [2:0]              brightness,
  input  logic                    update,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_done
);

  localparam int c_TW = $clog2(SCAN_DIV);
  localparam int c_IW = $clog2(NUM_DIGITS);
  // Wide enough to hold 8*SCAN_DIV without overflow.
  localparam int c_BW = c_TW + 4;

  localparam logic [c_TW-1:0]       c_TIMER_MAX  = c_TW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0]       c_INDEX_MAX  = c_IW'(NUM_DIGITS - 1);
  localparam logic [c_BW-1:0]       c_SCAN_DIV_W = c_BW'(SCAN_DIV);
  localparam logic [0:6]            c_SEG_OFF    = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] c_DIGIT_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  // Scan position
  logic [c_TW-1:0] r_timer;
  logic [c_IW-1:0] r_index;
  logic            w_frame_end;

  // Shadow / active buffers
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [NUM_DIGITS-1:0]   r_shadow_blank;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  // Current-digit selection and decode
  logic [3:0]            w_code;
  logic                  w_sel_dp;
  logic                  w_sel_blank;
  logic                  w_sel_lzb;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_lzb;
  logic [0:6]            w_seg_on;
  logic                  w_dark;
  logic [c_BW-1:0]       w_slot_pos;
  logic [c_BW-1:0]       w_duty_lim;
  logic                  w_enable;

  assign w_frame_end = (r_timer == c_TIMER_MAX) && (r_index == c_INDEX_MAX);

  // --------------------------------------------------------------------------
  // Slot timer and digit index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_index <= '0;
    end else if (r_timer == c_TIMER_MAX) begin
      r_timer <= '0;
      r_index <= (r_index == c_INDEX_MAX) ? '0 : r_index + 1'b1;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer. Active data only changes at frame end so a frame is never
  // torn. An update landing exactly on frame end bypasses the shadow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_pending       <= 1'b0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_shadow_blank  <= '0;
      r_act_digits    <= '0;
      r_act_dp        <= '0;
      r_act_blank     <= '0;
    end else begin
      if (update) begin
        r_shadow_digits <= digits_in;
        r_shadow_dp     <= dp_in;
        r_shadow_blank  <= blank_in;
      end
      if (w_frame_end) begin
        if (update) begin
          r_act_digits <= digits_in;
          r_act_dp     <= dp_in;
          r_act_blank  <= blank_in;
        end else if (r_pending) begin
          r_act_digits <= r_shadow_digits;
          r_act_dp     <= r_shadow_dp;
          r_act_blank  <= r_shadow_blank;
        end
        r_pending <= 1'b0;
      end else if (update) begin
        r_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Select the digit currently being scanned
  // --------------------------------------------------------------------------
  always_comb begin
    w_code      = '0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_lzb   = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_index == c_IW'(i)) begin
        w_code      = r_act_digits[4*i +: 4];
        w_sel_dp    = r_act_dp[i];
        w_sel_blank = r_act_blank[i];
        w_sel_lzb   = w_lzb[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // Digit i (i > 0) is a leading zero when it and every digit above it are
  // zero. Digit 0 always shows so a zero value still reads "0".
  always_comb begin
    logic w_zero_above;
    w_lzb        = '0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_act_digits[4*i +: 4] == 4'd0);
      w_lzb[i]     = w_zero_above;
    end
  end
`else
  assign w_lzb = '0;
`endif

  // --------------------------------------------------------------------------
  // Hex decode, active-high sense, bit order a..g
  // --------------------------------------------------------------------------
  always_comb begin
    w_seg_on = 7'b0000000;
    case (w_code)
      4'h0: w_seg_on = 7'b1111110;
      4'h1: w_seg_on = 7'b0110000;
      4'h2: w_seg_on = 7'b1101101;
      4'h3: w_seg_on = 7'b1111001;
      4'h4: w_seg_on = 7'b0110011;
      4'h5: w_seg_on = 7'b1011011;
      4'h6: w_seg_on = 7'b1011111;
      4'h7: w_seg_on = 7'b1110000;
      4'h8: w_seg_on = 7'b1111111;
      4'h9: w_seg_on = 7'b1111011;
      4'hA: w_seg_on = 7'b1110111;
      4'hB: w_seg_on = 7'b0011111;
      4'hC: w_seg_on = 7'b1001110;
      4'hD: w_seg_on = 7'b0111101;
      4'hE: w_seg_on = 7'b1001111;
      4'hF: w_seg_on = 7'b1000111;
      default: w_seg_on = 7'b0000000;
    endcase
  end

  assign w_dark = w_sel_blank | w_sel_lzb;

  // PWM: enable while timer*8 < (brightness+1)*SCAN_DIV
  assign w_slot_pos = c_BW'({r_timer, 3'b000});
  assign w_duty_lim = c_BW'({1'b0, brightness} + 4'd1) * c_SCAN_DIV_W;
  assign w_enable   = (w_slot_pos < w_duty_lim);

  // --------------------------------------------------------------------------
  // Output registers; polarity applied here so reset drives the off level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      seg        <= c_SEG_OFF;
      dp         <= ACTIVE_LOW;
      digit      <= c_DIGIT_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= (w_dark ? 7'b0000000 : w_seg_on) ^ c_SEG_OFF;
      dp         <= (~w_dark & w_sel_dp) ^ ACTIVE_LOW;
      digit      <= (w_enable ? w_onehot : '0) ^ c_DIGIT_OFF;
      frame_done <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Directed self-checking bench for seven_seg_scan with
//             NUM_DIGITS=4, SCAN_DIV=8, ACTIVE_LOW=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] digits_in  = '0;
  logic [3:0]  dp_in      = '0;
  logic [3:0]  blank_in   = '0;
  logic [2:0]  brightness = 3'd7;
  logic        update     = 1'b0;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  digit;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // posedges since reset release = upcoming scan state

  seven_seg_scan #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .update     (update),
    .seg        (seg),
    .dp         (dp),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic step();
    @(negedge clk_100MHz);
  endtask

  // Advance at least one cycle until the upcoming state is (digit d, timer t).
  // The output visible at that point reflects state (d, t-1).
  task automatic wait_state(input int d, input int t);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 70) begin
      step();
      n++;
      if (((cyc / 8) % 4) == d && (cyc % 8) == t) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_state(%0d,%0d): timeout, cyc=%0d required match", d, t, cyc);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    total++; if (digit !== 4'b1111) begin bad++; $display("FAIL reset_digit: got %b want 1111", digit); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    reset = 1'b0;
    step();
    total++; if (digit !== 4'b1110) begin bad++; $display("FAIL first_digit: got %b want 1110", digit); end
    total++; if (seg !== 7'b0000001) begin bad++; $display("FAIL first_seg: got %b want 0000001", seg); end
    wait_state(2, 3);
    total++; if (digit !== 4'b1011) begin bad++; $display("FAIL pre_reset_digit2: got %b want 1011", digit); end
    reset = 1'b1;
    #1;
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL midreset_seg: got %b want 1111111", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL midreset_dp: got %b want 1", dp); end
    total++; if (digit !== 4'b1111) begin bad++; $display("FAIL midreset_digit: got %b want 1111", digit); end
    step();
    reset = 1'b0;
    total++; if (digit !== 4'b1111) begin bad++; $display("FAIL release_digit: got %b want 1111", digit); end
    step();
    total++; if (digit !== 4'b1110) begin bad++; $display("FAIL restart_digit0: got %b want 1110", digit); end
  endtask

  task automatic test_scan_decode();
    logic [0:6] exp_seg [4];
    logic [3:0] exp_dig;
    exp_seg = '{7'b0000110, 7'b0001111, 7'b0001000, 7'b0000001};
    digits_in = 16'h0A73;
    update    = 1'b1;
    step();
    update    = 1'b0;
    wait_state(0, 1);
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 8; t++) begin
        exp_dig = ~(4'b0001 << d);
        total++; if (digit !== exp_dig) begin bad++; $display("FAIL scan_digit d%0d t%0d: got %b want %b", d, t, digit, exp_dig); end
        total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL scan_seg d%0d t%0d: got %b want %b", d, t, seg, exp_seg[d]); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL scan_dp d%0d t%0d: got %b want 1", d, t, dp); end
        total++; if (frame_done !== (cyc % 32 == 0)) begin bad++; $display("FAIL scan_frame_done cyc%0d: got %b want %b", cyc, frame_done, (cyc % 32 == 0)); end
        step();
      end
    end
  endtask

  task automatic test_mid_frame_update();
    wait_state(1, 3);
    digits_in = 16'h9999;
    update    = 1'b1;
    step();
    update    = 1'b0;
    total++; if (dut.r_pending !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", dut.r_pending); end
    wait_state(2, 1);
    total++; if (digit !== 4'b1011 || seg !== 7'b0001000) begin bad++; $display("FAIL mid_old_d2: got %b/%b want 1011/0001000", digit, seg); end
    wait_state(3, 1);
    total++; if (digit !== 4'b0111 || seg !== 7'b0000001) begin bad++; $display("FAIL mid_old_d3: got %b/%b want 0111/0000001", digit, seg); end
    wait_state(0, 1);
    total++; if (digit !== 4'b1110 || seg !== 7'b0000100) begin bad++; $display("FAIL mid_new_d0: got %b/%b want 1110/0000100", digit, seg); end
    wait_state(1, 1);
    total++; if (digit !== 4'b1101 || seg !== 7'b0000100) begin bad++; $display("FAIL mid_new_d1: got %b/%b want 1101/0000100", digit, seg); end
  endtask

  task automatic test_coincident_update();
    wait_state(3, 7);
    digits_in = 16'h4321;
    update    = 1'b1;
    step();
    update    = 1'b0;
    total++; if (dut.r_pending !== 1'b0) begin bad++; $display("FAIL coin_pending: got %b want 0", dut.r_pending); end
    total++; if (digit !== 4'b0111 || seg !== 7'b0000100) begin bad++; $display("FAIL coin_old_d3: got %b/%b want 0111/0000100", digit, seg); end
    step();
    total++; if (digit !== 4'b1110 || seg !== 7'b1001111) begin bad++; $display("FAIL coin_new_d0: got %b/%b want 1110/1001111", digit, seg); end
    wait_state(1, 1);
    total++; if (digit !== 4'b1101 || seg !== 7'b0010010) begin bad++; $display("FAIL coin_new_d1: got %b/%b want 1101/0010010", digit, seg); end
    total++; if (dut.r_pending !== 1'b0) begin bad++; $display("FAIL coin_pending_later: got %b want 0", dut.r_pending); end
  endtask

  task automatic test_brightness();
    int         on_cnt;
    logic [3:0] exp_dig;
    brightness = 3'd1;
    wait_state(3, 1);
    wait_state(0, 1);
    on_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      exp_dig = (t < 2) ? 4'b1110 : 4'b1111;
      if (digit == 4'b1110) on_cnt++;
      total++; if (digit !== exp_dig) begin bad++; $display("FAIL bright1_digit t%0d: got %b want %b", t, digit, exp_dig); end
      step();
    end
    total++; if (on_cnt !== 2) begin bad++; $display("FAIL bright1_on_cycles: got %0d want 2", on_cnt); end
    brightness = 3'd0;
    wait_state(3, 1);
    wait_state(0, 1);
    on_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      exp_dig = (t < 1) ? 4'b1110 : 4'b1111;
      if (digit == 4'b1110) on_cnt++;
      total++; if (digit !== exp_dig) begin bad++; $display("FAIL bright0_digit t%0d: got %b want %b", t, digit, exp_dig); end
      step();
    end
    total++; if (on_cnt !== 1) begin bad++; $display("FAIL bright0_on_cycles: got %0d want 1", on_cnt); end
    brightness = 3'd7;
  endtask

  task automatic test_back_to_back();
    logic [0:6] exp_seg [4];
    exp_seg = '{7'b0110000, 7'b1000010, 7'b0110001, 7'b1100000};
    wait_state(1, 2);
    digits_in = 16'h1111;
    update    = 1'b1;
    step();
    digits_in = 16'hBCDE;
    step();
    update    = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_state(d, 1);
      total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL b2b_seg d%0d: got %b want %b", d, seg, exp_seg[d]); end
    end
  endtask

  task automatic test_blanking();
    logic [0:6] exp_seg;
    logic       exp_dp;
    wait_state(1, 2);
    digits_in = 16'h0005;
    dp_in     = 4'b0100;
    blank_in  = 4'b0000;
    update    = 1'b1;
    step();
    update    = 1'b0;
    wait_state(0, 1);
    total++; if (digit !== 4'b1110 || seg !== 7'b0100100 || dp !== 1'b1) begin bad++; $display("FAIL blank_d0: got %b/%b/%b want 1110/0100100/1", digit, seg, dp); end
    for (int d = 1; d < 4; d++) begin
      wait_state(d, 1);
`ifdef SEVEN_SEG_LZB_EN
      exp_seg = 7'b1111111;
      exp_dp  = 1'b1;
`else
      exp_seg = 7'b0000001;
      exp_dp  = (d == 2) ? 1'b0 : 1'b1;
`endif
      total++; if (seg !== exp_seg || dp !== exp_dp) begin bad++; $display("FAIL lzb_d%0d: got %b/%b want %b/%b", d, seg, dp, exp_seg, exp_dp); end
      total++; if (digit !== ~(4'b0001 << d)) begin bad++; $display("FAIL lzb_digit d%0d: got %b", d, digit); end
    end
    wait_state(1, 2);
    blank_in = 4'b0001;
    update   = 1'b1;
    step();
    update   = 1'b0;
    wait_state(0, 1);
    total++; if (digit !== 4'b1110 || seg !== 7'b1111111 || dp !== 1'b1) begin bad++; $display("FAIL blank_in_d0: got %b/%b/%b want 1110/1111111/1", digit, seg, dp); end
  endtask

  initial begin
    test_reset();
    test_scan_decode();
    test_mid_frame_update();
    test_coincident_update();
    test_brightness();
    test_back_to_back();
    test_blanking();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
